// File: rtl/fft_adc_loader.sv
// Front-end loader for fft_top: writes one 2048-sample ADC frame across four
// RAM banks, launches the FFT, then waits for a rising oRDY before re-arming.
module fft_adc_loader #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 9,
  parameter int BANKS  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic [DATA_W-1:0] iDATA,
  input  logic              iVALID,
  input  logic              iFFT_RDY,
  output logic [DATA_W-1:0] oDATA,
  output logic [ADDR_W-1:0] oADDR_WR_0,
  output logic [ADDR_W-1:0] oADDR_WR_1,
  output logic [ADDR_W-1:0] oADDR_WR_2,
  output logic [ADDR_W-1:0] oADDR_WR_3,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3,
  output logic              oSTART,
  output logic              oACCEPT,
  output logic              oOVERRUN,
  output logic [CNT_W-1:0]  oDROP_CNT,
  output logic [7:0]        oFRAMES
);

  localparam int BANK_W = $clog2(BANKS);
  localparam int SCNT_W = ADDR_W + BANK_W;

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT_FFT} state_e;

  state_e                        state_q, state_d;
  logic [SCNT_W-1:0]             cnt_q, cnt_d;
  logic                          rdy_q;
  logic [DATA_W-1:0]             data_q, data_d;
  logic [BANKS-1:0][ADDR_W-1:0]  addr_q, addr_d;
  logic [BANKS-1:0]              we_q, we_d;
  logic                          start_q, start_d;
  logic                          accept_q, accept_d;
  logic                          overrun_q, overrun_d;
  logic [CNT_W-1:0]              drop_cnt_q, drop_cnt_d;
  logic [7:0]                    frames_q, frames_d;

  logic              take;
  logic              rdy_rise;
  logic [BANK_W-1:0] bank;

  assign take     = (state_q == FILL) && iVALID;
  assign rdy_rise = (state_q == WAIT_FFT) && iFFT_RDY && !rdy_q;
  assign bank     = cnt_q[SCNT_W-1:ADDR_W];

  always_ff @(posedge iCLK) begin
    if (iRESET) state_q <= FILL;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL:     if (take && (&cnt_q)) state_d = LAUNCH;
      LAUNCH:   state_d = WAIT_FFT;
      WAIT_FFT: if (rdy_rise) state_d = FILL;
      default:  state_d = FILL;
    endcase
  end

  always_comb begin
    cnt_d      = cnt_q;
    data_d     = data_q;
    addr_d     = addr_q;
    we_d       = '0;
    start_d    = (state_q == LAUNCH);
    accept_d   = (state_d == FILL);
    overrun_d  = overrun_q;
    drop_cnt_d = drop_cnt_q;
    frames_d   = frames_q;
    if (take) begin
      data_d       = iDATA;
      addr_d[bank] = cnt_q[ADDR_W-1:0];
      we_d[bank]   = 1'b1;
      cnt_d        = cnt_q + SCNT_W'(1);
    end
    if (iVALID && (state_q != FILL)) begin
      overrun_d = 1'b1;
      if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
    if (rdy_rise) frames_d = frames_q + 8'd1;
  end

  // rdy_q follows iFFT_RDY every cycle, so a level already high at launch
  // never looks like a fresh edge; only a low-then-high sequence completes.
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      data_q     <= '0;
      addr_q     <= '0;
      we_q       <= '0;
      start_q    <= 1'b0;
      accept_q   <= 1'b1;
      overrun_q  <= 1'b0;
      drop_cnt_q <= '0;
      frames_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      rdy_q      <= iFFT_RDY;
      data_q     <= data_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      start_q    <= start_d;
      accept_q   <= accept_d;
      overrun_q  <= overrun_d;
      drop_cnt_q <= drop_cnt_d;
      frames_q   <= frames_d;
    end
  end

  assign oDATA      = data_q;
  assign oADDR_WR_0 = addr_q[0];
  assign oADDR_WR_1 = addr_q[1];
  assign oADDR_WR_2 = addr_q[2];
  assign oADDR_WR_3 = addr_q[3];
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oSTART     = start_q;
  assign oACCEPT    = accept_q;
  assign oOVERRUN   = overrun_q;
  assign oDROP_CNT  = drop_cnt_q;
  assign oFRAMES    = frames_q;

endmodule

// File: tb/tb_fft_adc_loader.sv
// Bench for fft_adc_loader: full-size instance checked every cycle against a
// frame-level model, plus a tiny-frame instance for saturation and wrap.
module tb_fft_adc_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, valid, rdy;
  logic [15:0] din;
  logic [15:0] o_data;
  logic [8:0]  o_addr0, o_addr1, o_addr2, o_addr3;
  logic        o_we0, o_we1, o_we2, o_we3;
  logic        o_start, o_accept, o_ovr;
  logic [15:0] o_drops;
  logic [7:0]  o_frames;

  fft_adc_loader #(.DATA_W(16), .ADDR_W(9), .BANKS(4), .CNT_W(16)) dut (
    .iCLK(clk), .iRESET(rst), .iDATA(din), .iVALID(valid), .iFFT_RDY(rdy),
    .oDATA(o_data),
    .oADDR_WR_0(o_addr0), .oADDR_WR_1(o_addr1), .oADDR_WR_2(o_addr2), .oADDR_WR_3(o_addr3),
    .oWE_0(o_we0), .oWE_1(o_we1), .oWE_2(o_we2), .oWE_3(o_we3),
    .oSTART(o_start), .oACCEPT(o_accept), .oOVERRUN(o_ovr),
    .oDROP_CNT(o_drops), .oFRAMES(o_frames)
  );

  logic        s_rst, s_valid, s_rdy;
  logic [15:0] s_din;
  logic [15:0] s_data;
  logic [1:0]  s_addr0, s_addr1, s_addr2, s_addr3;
  logic        s_we0, s_we1, s_we2, s_we3;
  logic        s_start, s_accept, s_ovr;
  logic [3:0]  s_drops;
  logic [7:0]  s_frames;

  fft_adc_loader #(.DATA_W(16), .ADDR_W(2), .BANKS(4), .CNT_W(4)) dut_s (
    .iCLK(clk), .iRESET(s_rst), .iDATA(s_din), .iVALID(s_valid), .iFFT_RDY(s_rdy),
    .oDATA(s_data),
    .oADDR_WR_0(s_addr0), .oADDR_WR_1(s_addr1), .oADDR_WR_2(s_addr2), .oADDR_WR_3(s_addr3),
    .oWE_0(s_we0), .oWE_1(s_we1), .oWE_2(s_we2), .oWE_3(s_we3),
    .oSTART(s_start), .oACCEPT(s_accept), .oOVERRUN(s_ovr),
    .oDROP_CNT(s_drops), .oFRAMES(s_frames)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame-level reference: samples fill slots 0..2047 in order; a full frame
  // launches one cycle later, then only a low-to-high RDY sequence re-arms.
  int          cyc = 0;
  bit          chk_en = 0;
  int          m_filled, m_phase, m_frames, m_drops;
  bit          m_prev_rdy, m_ovr;
  logic [3:0]  e_we;
  logic [8:0]  e_addr [4];
  logic [15:0] e_data;
  bit          e_start, e_accept;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_filled = 0; m_phase = 0; m_frames = 0; m_drops = 0;
      m_prev_rdy = 0; m_ovr = 0;
      e_we = '0; e_data = '0; e_start = 0; e_accept = 1;
      for (int b = 0; b < 4; b++) e_addr[b] = '0;
      chk_en = 1;
    end else begin
      e_we = '0;
      e_start = 0;
      if (m_phase == 0) begin
        if (valid) begin
          e_we[m_filled / 512]   = 1'b1;
          e_addr[m_filled / 512] = 9'(m_filled % 512);
          e_data = din;
          m_filled++;
          if (m_filled == 2048) begin
            m_filled = 0;
            m_phase  = 1;
          end
        end
      end else begin
        if (valid) begin
          m_ovr = 1;
          if (m_drops < 65535) m_drops++;
        end
        if (m_phase == 1) begin
          e_start = 1;
          m_phase = 2;
        end else if (rdy && !m_prev_rdy) begin
          m_phase  = 0;
          m_frames = (m_frames + 1) % 256;
        end
      end
      e_accept   = (m_phase == 0);
      m_prev_rdy = rdy;
    end
  end

  int we_cnt = 0, start_cnt = 0, last_we_cyc = 0, start_cyc = 0, s_start_cnt = 0;
  bit seq_data = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("we", 32'({o_we3, o_we2, o_we1, o_we0}), 32'(e_we));
      chk("addr0", 32'(o_addr0), 32'(e_addr[0]));
      chk("addr1", 32'(o_addr1), 32'(e_addr[1]));
      chk("addr2", 32'(o_addr2), 32'(e_addr[2]));
      chk("addr3", 32'(o_addr3), 32'(e_addr[3]));
      if (e_we != 0) chk("data", 32'(o_data), 32'(e_data));
      chk("start", 32'(o_start), 32'(e_start));
      chk("accept", 32'(o_accept), 32'(e_accept));
      chk("drops", 32'(o_drops), 32'(m_drops));
      chk("overrun", 32'(o_ovr), 32'(m_ovr));
      chk("frames", 32'(o_frames), 32'(m_frames));
      if (o_we0 | o_we1 | o_we2 | o_we3) begin
        we_cnt++;
        last_we_cyc = cyc;
        if (seq_data) begin
          if (o_we0) chk("seq_b0", 32'(o_data), 32'(o_addr0));
          if (o_we1) chk("seq_b1", 32'(o_data), 512 + 32'(o_addr1));
          if (o_we2) chk("seq_b2", 32'(o_data), 1024 + 32'(o_addr2));
          if (o_we3) chk("seq_b3", 32'(o_data), 1536 + 32'(o_addr3));
        end
      end
      if (o_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
    end
    if (s_start === 1'b1) s_start_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rdy_pulse();
    rdy = 0; step(); step();
    rdy = 1; step();
  endtask

  task automatic s_frame();
    s_valid = 1;
    repeat (16) step();
    s_valid = 0;
    repeat (3) step();
    s_rdy = 0; step(); step();
    s_rdy = 1; step(); step();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  int sc, wc, n, guard;

  initial begin
    rst = 1; valid = 0; rdy = 1; din = '0;
    s_rst = 1; s_valid = 0; s_rdy = 1; s_din = '0;
    repeat (3) step();
    rst = 0; s_rst = 0;
    @(negedge clk);
    chk("rst_accept", 32'(o_accept), 32'd1);
    chk("rst_we", 32'({o_we3, o_we2, o_we1, o_we0}), 32'd0);
    chk("rst_drops", 32'(o_drops), 32'd0);

    // Sequential-data frame with RDY held high throughout.
    seq_data = 1; we_cnt = 0; start_cnt = 0;
    for (int i = 0; i < 2048; i++) begin
      valid = 1; din = 16'(i); step();
    end
    valid = 0;
    repeat (3) step();
    seq_data = 0;
    @(negedge clk);
    chk("f1_we_cnt", 32'(we_cnt), 32'd2048);
    chk("f1_start_cnt", 32'(start_cnt), 32'd1);
    chk("f1_start_lat", 32'(start_cyc - last_we_cyc), 32'd1);

    repeat (5) step();
    @(negedge clk);
    chk("held_rdy_frames", 32'(o_frames), 32'd0);
    chk("held_rdy_accept", 32'(o_accept), 32'd0);
    rdy = 0;
    repeat (10) step();
    @(negedge clk);
    chk("low_rdy_frames", 32'(o_frames), 32'd0);
    rdy = 1;
    step();
    @(negedge clk);
    chk("rise_frames", 32'(o_frames), 32'd1);
    chk("rise_accept", 32'(o_accept), 32'd1);

    // Random frame, then 300 samples presented while waiting on the FFT.
    for (int i = 0; i < 2048; i++) begin
      valid = 1; din = 16'($urandom); step();
    end
    valid = 0;
    repeat (3) step();
    wc = we_cnt;
    valid = 1;
    repeat (300) step();
    valid = 0;
    step();
    @(negedge clk);
    chk("drop_cnt_300", 32'(o_drops), 32'd300);
    chk("drop_overrun", 32'(o_ovr), 32'd1);
    chk("drop_no_we", 32'(we_cnt - wc), 32'd0);
    rdy_pulse();
    valid = 1; din = 16'($urandom); step();
    @(negedge clk);
    chk("next_we0", 32'(o_we0), 32'd1);
    chk("next_addr0", 32'(o_addr0), 32'd0);

    // Abort after 700 samples, then a full frame from scratch.
    for (int i = 1; i < 700; i++) begin
      valid = 1; din = 16'($urandom); step();
    end
    valid = 0;
    rst = 1; step(); step();
    rst = 0;
    sc = start_cnt;
    valid = 1; din = 16'hBEEF; step();
    @(negedge clk);
    chk("post_rst_we0", 32'(o_we0), 32'd1);
    chk("post_rst_addr0", 32'(o_addr0), 32'd0);
    for (int i = 1; i < 2047; i++) begin
      valid = 1; din = 16'($urandom); step();
    end
    valid = 0;
    repeat (4) step();
    @(negedge clk);
    chk("abort_no_start", 32'(start_cnt - sc), 32'd0);
    valid = 1; din = 16'($urandom); step();
    valid = 0;
    repeat (3) step();
    @(negedge clk);
    chk("abort_one_start", 32'(start_cnt - sc), 32'd1);

    // Sparse (~30%) valid strobe with sequential data.
    rdy_pulse();
    seq_data = 1; we_cnt = 0; sc = start_cnt;
    n = 0; guard = 0;
    while (n < 2048 && guard < 30000) begin
      valid = ($urandom_range(99) < 30);
      din = 16'(n);
      if (valid) n++;
      guard++;
      step();
    end
    valid = 0;
    repeat (3) step();
    seq_data = 0;
    @(negedge clk);
    chk("sparse_we_cnt", 32'(we_cnt), 32'd2048);
    chk("sparse_start", 32'(start_cnt - sc), 32'd1);
    chk("sparse_start_lat", 32'(start_cyc - last_we_cyc), 32'd1);

    // Tiny-frame instance: drop-counter saturation and frame-counter wrap.
    s_valid = 1;
    repeat (16) step();
    s_valid = 0;
    repeat (3) step();
    s_valid = 1;
    repeat (20) step();
    s_valid = 0;
    step();
    @(negedge clk);
    chk("sat_drops", 32'(s_drops), 32'd15);
    chk("sat_overrun", 32'(s_ovr), 32'd1);
    s_rdy = 0; step(); step();
    s_rdy = 1; step(); step();
    @(negedge clk);
    chk("small_frames1", 32'(s_frames), 32'd1);
    for (int f = 0; f < 256; f++) s_frame();
    @(negedge clk);
    chk("wrap_frames", 32'(s_frames), 32'd1);
    chk("wrap_starts", 32'(s_start_cnt), 32'd257);
    chk("wrap_accept", 32'(s_accept), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
